// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//
// Shared definitions for the pipelined ripple-carry adder (adder_pipe).
//
// Contents:
//   ADDER_WIDTH / ADDER_STAGES  default operand width and pipeline depth
//   ADDER_MAX_WIDTH             widest adder the stage-register struct can hold
//   chunk_width()               carry-chain chunk width for a WIDTH/STAGES pair
//   stage_t                     one pipeline stage register
//
// Optional feature macro: ADDER_PIPE_OVF_EN adds operand sign bits to stage_t
// so the signed-overflow flag can be formed alongside the final sum.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_WIDTH     = 32;
    localparam int ADDER_STAGES    = 4;

    // Packed structs cannot be parameterised, so the data fields are sized for
    // the widest supported adder. A narrower adder only ever writes the low
    // WIDTH bits; everything above stays at zero.
    localparam int ADDER_MAX_WIDTH = 128;

    // Width of the carry-chain slice handled by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // One stage register. `sum` holds the chunks already computed (lower bits),
    // `a`/`b` hold the operand chunks that later stages still have to add; the
    // chunks already consumed are zeroed as they leave their stage.
    typedef struct packed {
        logic                       valid;
        logic                       carry;
        logic [ADDER_MAX_WIDTH-1:0] sum;
        logic [ADDER_MAX_WIDTH-1:0] a;
        logic [ADDER_MAX_WIDTH-1:0] b;
`ifdef ADDER_PIPE_OVF_EN
        logic                       sign_a;
        logic                       sign_b;
`endif
    } stage_t;

endpackage

// File: rtl/adder_pipe_if.sv
// -----------------------------------------------------------------------------
// adder_pipe_if
//
// Valid/ready stream bundle between an operand producer, the adder pipeline
// and a result consumer.
//
// Signals:
//   in_valid  producer -> adder   operand set valid
//   in_ready  adder -> producer   operand set accepted this cycle
//   in1, in2  producer -> adder   WIDTH-bit operands
//   cin       producer -> adder   carry-in
//   out_valid adder -> consumer   sum/cout hold a result
//   out_ready consumer -> adder   result taken this cycle
//   sum       adder -> consumer   low WIDTH bits of in1 + in2 + cin
//   cout      adder -> consumer   carry out of the MSB
//   ovf       adder -> consumer   signed overflow (only with ADDER_PIPE_OVF_EN)
//
// Modports: master = the testbench / surrounding datapath, slave = adder_pipe.
// -----------------------------------------------------------------------------
interface adder_pipe_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_PIPE_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid,
        output in1,
        output in2,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout
`ifdef ADDER_PIPE_OVF_EN
        ,
        input  ovf
`endif
    );

    modport slave (
        input  in_valid,
        input  in1,
        input  in2,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout
`ifdef ADDER_PIPE_OVF_EN
        ,
        output ovf
`endif
    );

endinterface

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
//
// Purely combinational WIDTH-bit ripple-carry slice. One instance per pipeline
// stage; the enclosing adder_pipe owns every register around it.
//
// Ports:
//   a, b  input  WIDTH  operand chunks
//   ci    input  1      carry into bit 0
//   s     output WIDTH  chunk sum
//   co    output 1      carry out of bit WIDTH-1
//
// No configuration macros affect this file (ADDER_PIPE_OVF_EN is handled by
// the top level).
// -----------------------------------------------------------------------------
module adder_chunk #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    // The carry is walked through a single loop variable rather than a carry
    // vector so the chain is expressed as one combinational process.
    always_comb begin
        logic carry;
        carry = ci;
        s     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
//
// Pipelined ripple-carry adder with a valid/ready stream interface.
// {cout, sum} = in1 + in2 + cin, unsigned modulo 2^WIDTH.
//
// The carry chain is cut into STAGES chunks of CHUNK = WIDTH/STAGES bits.
// Stage k adds operand bits [k*CHUNK +: CHUNK] with the registered carry from
// stage k-1 (cin for stage 0) and registers: its carry-out, the sum chunks
// produced so far, and the operand chunks not yet consumed. The last stage
// register drives the outputs directly, so there is no combinational path
// from in1/in2/cin to any output.
//
// Flow control is a single global advance: adv = !out_valid || out_ready.
// On adv every stage shifts one place (bubbles included); otherwise all stage
// registers hold. in_ready = adv and never depends on in_valid.
//
// Ports:
//   clk   input  clock, rising edge
//   rst   input  synchronous active-high reset; drops everything in flight
//   bus   adder_pipe_if.slave  in_valid/in_ready/in1/in2/cin,
//                              out_valid/out_ready/sum/cout[/ovf]
//
// Parameters: WIDTH (operand width), STAGES (pipeline depth, divides WIDTH).
//
// Optional feature macro: ADDER_PIPE_OVF_EN
//   defined   -> bus.ovf is driven with the signed-overflow flag; operand sign
//                bits travel down the pipe next to the data.
//   undefined -> no ovf port and no sign-bit registers.
// -----------------------------------------------------------------------------
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH,
    parameter int STAGES = ADDER_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    adder_pipe_if.slave  bus
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    // Refuse to elaborate configurations the chunked pipeline cannot express.
    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH ||
        (WIDTH % STAGES) != 0 || WIDTH > ADDER_MAX_WIDTH) begin : gen_bad_cfg
        $error("adder_pipe: illegal WIDTH/STAGES combination");
    end

    stage_t st_reg  [STAGES];
    stage_t st_next [STAGES];
    logic   adv;

    // Global advance: the whole pipe moves unless a finished result is
    // waiting for a consumer that is not ready.
    assign adv          = !st_reg[STAGES-1].valid || bus.out_ready;
    assign bus.in_ready = adv;

    // -------------------------------------------------------------------------
    // Per-stage next-state: one ripple slice plus the bookkeeping that moves
    // the partially built sum and remaining operands one stage down.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
        logic [CHUNK-1:0] op_a;
        logic [CHUNK-1:0] op_b;
        logic [CHUNK-1:0] s;
        logic             ci;
        logic             co;
        stage_t           nxt;

        if (gi == 0) begin : gen_head
            assign op_a = bus.in1[0 +: CHUNK];
            assign op_b = bus.in2[0 +: CHUNK];
            assign ci   = bus.cin;

            always_comb begin
                nxt                  = '0;
                nxt.valid            = bus.in_valid;
                nxt.carry            = co;
                nxt.sum[0 +: CHUNK]  = s;
                nxt.a[WIDTH-1:0]     = bus.in1;
                nxt.b[WIDTH-1:0]     = bus.in2;
                // The lowest chunk is consumed here.
                nxt.a[0 +: CHUNK]    = '0;
                nxt.b[0 +: CHUNK]    = '0;
`ifdef ADDER_PIPE_OVF_EN
                nxt.sign_a           = bus.in1[WIDTH-1];
                nxt.sign_b           = bus.in2[WIDTH-1];
`endif
            end
        end else begin : gen_body
            assign op_a = st_reg[gi-1].a[gi*CHUNK +: CHUNK];
            assign op_b = st_reg[gi-1].b[gi*CHUNK +: CHUNK];
            assign ci   = st_reg[gi-1].carry;

            // Everything else (valid, lower sum chunks, sign bits) is
            // forwarded unchanged from the previous stage.
            always_comb begin
                nxt                        = st_reg[gi-1];
                nxt.carry                  = co;
                nxt.sum[gi*CHUNK +: CHUNK] = s;
                nxt.a[gi*CHUNK +: CHUNK]   = '0;
                nxt.b[gi*CHUNK +: CHUNK]   = '0;
            end
        end

        adder_chunk #(
            .WIDTH (CHUNK)
        ) u_chunk (
            .a  (op_a),
            .b  (op_b),
            .ci (ci),
            .s  (s),
            .co (co)
        );

        assign st_next[gi] = nxt;
    end

    // -------------------------------------------------------------------------
    // Stage registers. Reset wins over adv, so an in-flight transaction can
    // never surface after a reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                st_reg[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                st_reg[i] <= st_next[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs straight from the last stage register.
    // -------------------------------------------------------------------------
    assign bus.out_valid = st_reg[STAGES-1].valid;
    assign bus.sum       = st_reg[STAGES-1].sum[WIDTH-1:0];
    assign bus.cout      = st_reg[STAGES-1].carry;

`ifdef ADDER_PIPE_OVF_EN
    // Same-signed operands producing a result of the opposite sign.
    assign bus.ovf = (st_reg[STAGES-1].sign_a == st_reg[STAGES-1].sign_b) &&
                     (st_reg[STAGES-1].sum[WIDTH-1] != st_reg[STAGES-1].sign_a);
`endif

    // The last stage's operand fields are fully consumed (always zero) and its
    // sum bits above WIDTH are never driven; fold them into one sink.
    logic unused_tail;
    assign unused_tail = ^{st_reg[STAGES-1].a,
                           st_reg[STAGES-1].b,
                           st_reg[STAGES-1].sum};

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
//
// Self-checking bench for adder_pipe. Two instances: WIDTH=32/STAGES=4 (main)
// and WIDTH=8/STAGES=1 (single registered adder). Results of the main DUT are
// checked against an in-order queue of {ovf, cout, sum} values computed with
// plain integer arithmetic when each operand set is accepted.
// Honours ADDER_PIPE_OVF_EN for the ovf checks.
// -----------------------------------------------------------------------------
module tb_adder_pipe;
    import adder_pkg::*;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adder_pipe_if #(.WIDTH(W))  bus  ();
    adder_pipe_if #(.WIDTH(W8)) bus8 ();

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    adder_pipe #(.WIDTH(W8), .STAGES(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;

    logic [W+1:0] exp_q[$];     // {ovf, cout, sum} in acceptance order
    int           out_cyc_q[$]; // cycle index of every result handshake

    // Reference: exact integer sum, then the sign-rule for overflow.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic c);
        logic [W:0] full;
        logic       ov;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: record accepts and check handshaken results, then advance.
    task automatic tick();
        logic         acc;
        logic         hand;
        logic [W+1:0] e;
        acc  = bus.in_valid && bus.in_ready;
        hand = bus.out_valid && bus.out_ready;
        if (acc) exp_q.push_back(ref_add(bus.in1, bus.in2, bus.cin));
        if (hand) begin
            n_out++;
            out_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(hand), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_sum", 64'(bus.sum), 64'(e[W-1:0]));
                check("sb_cout", 64'(bus.cout), 64'(e[W]));
`ifdef ADDER_PIPE_OVF_EN
                check("sb_ovf", 64'(bus.ovf), 64'(e[W+1]));
`endif
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) exp_q.delete();
    endtask

    // Send one operand set and wait (bounded) for a result to appear.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, output int lat);
        bus.in1      = a;
        bus.in2      = b;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) check("result_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        int         drops;
        int         n_acc;
        int         n0;
        logic [7:0] a8, b8;
        logic       c8;
        logic [8:0] full8;

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in1        = '0;
        bus.in2        = '0;
        bus.cin        = 1'b0;
        bus.out_ready  = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in1       = '0;
        bus8.in2       = '0;
        bus8.cin       = 1'b0;
        bus8.out_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_w8_out_valid", 64'(bus8.out_valid), 64'd0);
`ifdef ADDER_PIPE_OVF_EN
        check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif

        // Carry rippling through every stage; latency S-1 edges after accept.
        run_one(32'hFFFF_FFFF, 32'h0, 1'b1, lat);
        check("ripple_latency", 64'(lat), 64'(S - 1));
        check("ripple_sum", 64'(bus.sum), 64'h0);
        check("ripple_cout", 64'(bus.cout), 64'd1);
        tick();

        // 100 back-to-back random operand sets with out_ready held high.
        out_cyc_q.delete();
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            bus.in1 = $urandom;
            bus.in2 = (i % 7 == 0) ? ~bus.in1 : $urandom;
            bus.cin = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            if (!bus.in_ready) drops++;
            tick();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("stream_ready_drops", 64'(drops), 64'd0);
        check("stream_count", 64'(out_cyc_q.size()), 64'd100);
        if (out_cyc_q.size() == 100)
            check("stream_span", 64'(out_cyc_q[99] - out_cyc_q[0]), 64'd99);

        // Stall: hold out_ready low for 5 cycles once results start.
        n_acc = 0;
        n0    = n_out;
        for (int k = 0; k < 20 && !bus.out_valid; k++) begin
            bus.in1 = $urandom;
            bus.in2 = $urandom;
            bus.cin = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            if (bus.in_ready) n_acc++;
            tick();
        end
        check("stall_reached", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            bus.in1 = $urandom;
            bus.in2 = $urandom;
            bus.in_valid = 1'b1;
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_sum", 64'(bus.sum), 64'(exp_q[0][W-1:0]));
            check("stall_cout", 64'(bus.cout), 64'(exp_q[0][W]));
`ifdef ADDER_PIPE_OVF_EN
            check("stall_ovf", 64'(bus.ovf), 64'(exp_q[0][W+1]));
`endif
            tick();
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick();
        check("stall_count", 64'(n_out - n0), 64'(n_acc));
        check("stall_drained", 64'(bus.out_valid), 64'd0);

        // Reset with three transactions in flight.
        n0 = n_out;
        for (int i = 0; i < 3; i++) begin
            bus.in1 = $urandom;
            bus.in2 = $urandom;
            bus.cin = 1'b1;
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_sum", 64'(bus.sum), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < 10; k++) tick();
        check("midrst_no_result", 64'(n_out - n0), 64'd0);

        // WIDTH=8, STAGES=1: latency one, legacy 8-bit adder values.
        bus8.in1      = 8'hA5;
        bus8.in2      = 8'h5B;
        bus8.cin      = 1'b1;
        bus8.in_valid = 1'b1;
        check("w8_in_ready", 64'(bus8.in_ready), 64'd1);
        tick();
        check("w8_valid", 64'(bus8.out_valid), 64'd1);
        check("w8_sum", 64'(bus8.sum), 64'h01);
        check("w8_cout", 64'(bus8.cout), 64'd1);
        for (int i = 0; i < 6; i++) begin
            a8    = 8'($urandom);
            b8    = 8'($urandom);
            c8    = 1'($urandom_range(0, 1));
            full8 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
            bus8.in1 = a8;
            bus8.in2 = b8;
            bus8.cin = c8;
            tick();
            check("w8_rand_sum", 64'(bus8.sum), 64'(full8[7:0]));
            check("w8_rand_cout", 64'(bus8.cout), 64'(full8[8]));
        end
        bus8.in_valid = 1'b0;
        tick();
        check("w8_idle", 64'(bus8.out_valid), 64'd0);

`ifdef ADDER_PIPE_OVF_EN
        // Signed overflow, positive and negative.
        run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        check("ovf_pos_sum", 64'(bus.sum), 64'h8000_0000);
        check("ovf_pos_ovf", 64'(bus.ovf), 64'd1);
        check("ovf_pos_cout", 64'(bus.cout), 64'd0);
        tick();
        run_one(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        check("ovf_neg_sum", 64'(bus.sum), 64'h0);
        check("ovf_neg_ovf", 64'(bus.ovf), 64'd1);
        check("ovf_neg_cout", 64'(bus.cout), 64'd1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined ripple-carry adder with a valid/ready stream interface. It computes WIDTH-bit `sum` and `cout` from `in1`, `in2` and `cin`. The carry chain is split into STAGES equal chunks, one register stage per chunk, so wide adds meet timing at one result per cycle. It replaces the fixed 8-bit combinational adder wherever an adder sits on a clocked datapath.

## Interface
- WIDTH, 32, operand and sum width in bits. Must be ≥ 1.
- STAGES, 4, number of pipeline stages and carry-chain chunks.
  - Must satisfy 1 ≤ STAGES ≤ WIDTH.
  - WIDTH % STAGES must be 0; elaboration fails otherwise.
- clk  input  1  clock. All logic is on the rising edge.
- rst  input  1  reset. Synchronous and active-high.
- in_valid  input  1  the operand set is valid.
- in_ready  output  1  the block accepts an operand set this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  `sum` and `cout` hold a result.
- out_ready  input  1  the downstream consumer takes the result.
- sum  output  WIDTH  low WIDTH bits of in1 + in2 + cin.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow. Present only with ADDER_PIPE_OVF_EN.

## Operation
- CHUNK = WIDTH/STAGES.
- Stage k (k = 0..STAGES-1):
  - adds bits [k·CHUNK +: CHUNK] of the operands.
  - The carry into stage 0 is `cin`; the carry into every other stage is the registered carry from stage k-1.
  - It registers its partial sum, its carry-out and the still-unused upper operand chunks.
- Already-computed lower sum chunks are forwarded unchanged down the pipe, so every stage holds one transaction.
- Arithmetic is unsigned modulo 2^WIDTH. {cout, sum} = in1 + in2 + cin exactly.
- Flow control uses a global advance, adv = !out_valid || out_ready.
  - in_ready = adv. This is combinational from out_valid and out_ready only, never from in_valid.
  - On adv, every stage shifts one place and stage 0 captures its inputs together with in_valid.
  - On !adv, all stage registers hold. `sum`, `cout` and `ovf` stay stable while out_valid && !out_ready.
- Bubbles are not collapsed. An empty stage still occupies one slot.
- Reset:
  - All stage valid bits clear to 0, so out_valid = 0.
  - `sum`, `cout`, `ovf` and all data registers clear to 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation: every in-flight transaction is dropped silently and no partial result is emitted. Reset has priority over adv.
- Simultaneous events: an accept and a result handoff in the same cycle are both legal, giving full throughput.

## Timing
- Latency: an operand set accepted at edge t (in_valid && in_ready) gives out_valid = 1 after edge t+STAGES-1. Its value is present on the outputs from edge t+STAGES-1 onward.
- With out_ready held high, throughput is one result per cycle.
- Stall: each cycle with out_valid && !out_ready adds one cycle to every in-flight transaction.
- Critical path: one CHUNK-bit ripple plus a register. No combinational path from in1, in2 or cin to any output.
- STAGES = 1 gives a single registered WIDTH-bit adder with latency 1.

## Configuration
- ADDER_PIPE_OVF_EN defined:
  - Port `ovf` exists.
  - ovf = (in1[W-1] == in2[W-1]) && (sum[W-1] != in1[W-1]), where W = WIDTH.
  - The operand sign bits are piped alongside the data so `ovf` is aligned with `sum`.
  - `ovf` resets to 0.
- ADDER_PIPE_OVF_EN undefined: no `ovf` port, no sign-bit registers. All other behaviour is identical.

## Structure
- Package adder_pkg holds:
  - The WIDTH and STAGES defaults.
  - The CHUNK derivation function.
  - The stage-register struct typedef: valid, carry, partial sum, remaining operands and, when ADDER_PIPE_OVF_EN is defined, sign bits.
- Sub-module adder_chunk: a combinational CHUNK-bit ripple-carry slice with inputs a, b, ci and outputs s, co.
  - Instantiated STAGES times by a generate loop.
  - The top level owns all registers and the flow control.

## Test plan
- WIDTH=32, STAGES=4, out_ready=1. Apply in1=0xFFFFFFFF, in2=0, cin=1 at edge 0 → out_valid at edge 3 with sum=0x00000000, cout=1. This exercises the carry rippling through all stages.
- Stream 100 random operand sets back-to-back, out_ready=1 → in_ready stays 1, 100 results arrive on 100 consecutive cycles, in order, each matching the reference {cout, sum}.
- Hold out_ready=0 for 5 cycles once results start → sum, cout and ovf stay stable, in_ready=0, and no transaction is lost or duplicated after release.
- Assert rst with 3 transactions in flight → out_valid=0 and sum=0 the cycle after reset, and none of the 3 results ever appears.
- With ADDER_PIPE_OVF_EN defined: 0x7FFFFFFF + 0x00000001, cin=0 → sum=0x80000000, ovf=1, cout=0. Then 0x80000000 + 0x80000000 → sum=0, ovf=1, cout=1.
- WIDTH=8, STAGES=1: in1=0xA5, in2=0x5B, cin=1 → one cycle later sum=0x01, cout=1, matching the legacy 8-bit adder function.
